// File: rtl/repl_pkg.sv
// repl_pkg: replacement policy selection type and LFSR constants
package repl_pkg;
    typedef enum logic [1:0] {REPL_RR, REPL_LFSR, REPL_PLRU} repl_mode_t;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction
endpackage

// File: rtl/repl_plru_tree.sv
// repl_plru_tree: tree-PLRU victim walk for a lookup set and path update for an accessed way
module repl_plru_tree #(
    parameter int SET_ASSOC = 4
) (
    input  logic [SET_ASSOC-2:0]         lookup_bits,
    output logic [$clog2(SET_ASSOC)-1:0] victim,
    input  logic [SET_ASSOC-2:0]         update_bits,
    input  logic [$clog2(SET_ASSOC)-1:0] way,
    output logic [SET_ASSOC-2:0]         next_bits
);
    localparam int W = $clog2(SET_ASSOC);
    logic [W-1:0] rn, wn;
    // Leaf 2n+1+b maps to way (2n+1+b)-(SET_ASSOC-1), i.e. 2n+2+b modulo SET_ASSOC
    always_comb begin
        rn = '0;
        for (int l = 0; l < W - 1; l++) rn = (rn << 1) + W'(1) + W'(lookup_bits[rn]);
        victim = (rn << 1) + W'(2) + W'(lookup_bits[rn]);
    end
    // Each node on the path points at the sibling subtree; left children are odd nodes
    always_comb begin
        next_bits = update_bits;
        wn = (way >> 1) + W'(SET_ASSOC / 2 - 1);
        next_bits[wn] = ~way[0];
        for (int l = 1; l < W; l++) begin
            next_bits[(wn - W'(1)) >> 1] = wn[0];
            wn = (wn - W'(1)) >> 1;
        end
    end
endmodule

// File: rtl/repl_policy.sv
// repl_policy: per-set cache victim selection by round-robin, shared LFSR or tree-PLRU
module repl_policy
    import repl_pkg::*;
#(
    parameter int         SET_ASSOC = 4,
    parameter int         SET_NUM   = 64,
    parameter repl_mode_t MODE      = REPL_PLRU
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [$clog2(SET_NUM)-1:0]   access_set,
    input  logic [SET_ASSOC-1:0]         access,
    input  logic                         update,
    input  logic [$clog2(SET_NUM)-1:0]   repl_set,
    input  logic [SET_ASSOC-1:0]         valid,
    input  logic                         repl_commit,
    output logic [$clog2(SET_ASSOC)-1:0] repl_index
);
    localparam int W = $clog2(SET_ASSOC);
    logic [W-1:0] inv_way, acc_way, policy_way;
    logic         inv_hit, acc_hit, unused;
    always_comb begin
        inv_hit = 1'b0;
        inv_way = '0;
        acc_hit = 1'b0;
        acc_way = '0;
        for (int i = SET_ASSOC - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                inv_hit = 1'b1;
                inv_way = W'(i);
            end
            if (access[i]) begin
                acc_hit = 1'b1;
                acc_way = W'(i);
            end
        end
    end
    assign repl_index = inv_hit ? inv_way : policy_way;
    // Not every mode consumes every strobe
    assign unused = ^{update, access_set, acc_hit, acc_way, repl_commit, repl_set};
    if (MODE == REPL_RR) begin : g_rr
        logic [W-1:0] ptr [SET_NUM];
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i < SET_NUM; i++) ptr[i] <= '0;
            end else if (repl_commit) begin
                ptr[repl_set] <= ptr[repl_set] + W'(1);
            end
        end
        assign policy_way = ptr[repl_set];
    end else if (MODE == REPL_LFSR) begin : g_lfsr
        logic [15:0] lfsr;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) lfsr <= LFSR_SEED;
            else lfsr <= lfsr_step(lfsr);
        end
        assign policy_way = lfsr[W-1:0];
    end else begin : g_plru
        logic [SET_ASSOC-2:0] tree [SET_NUM];
        logic [SET_ASSOC-2:0] tree_nxt;
        repl_plru_tree #(.SET_ASSOC(SET_ASSOC)) u_tree (
            .lookup_bits(tree[repl_set]),
            .victim     (policy_way),
            .update_bits(tree[access_set]),
            .way        (acc_way),
            .next_bits  (tree_nxt)
        );
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i < SET_NUM; i++) tree[i] <= '0;
            end else if (update && acc_hit) begin
                tree[access_set] <= tree_nxt;
            end
        end
    end
endmodule

// File: tb/tb_repl_policy.sv
// tb_repl_policy: directed checks of RR, LFSR and PLRU instances sharing one stimulus
module tb_repl_policy;
    import repl_pkg::*;
    logic clk = 1'b0, rst = 1'b1;
    logic [5:0] access_set = '0, repl_set = '0;
    logic [3:0] access = '0, valid = 4'hF;
    logic update = 1'b0, repl_commit = 1'b0;
    logic [1:0] idx_rr, idx_lfsr, idx_plru;
    logic [15:0] model;
    logic [1:0] fill_exp [4] = '{2'd2, 2'd2, 2'd0, 2'd0};
    logic [1:0] rr_exp [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    int n_vec = 0, n_err = 0;
    always #5 clk = ~clk;

    repl_policy #(.SET_ASSOC(4), .SET_NUM(64), .MODE(REPL_RR)) u_rr (
        .clk(clk), .rst(rst), .access_set(access_set), .access(access), .update(update),
        .repl_set(repl_set), .valid(valid), .repl_commit(repl_commit), .repl_index(idx_rr));
    repl_policy #(.SET_ASSOC(4), .SET_NUM(64), .MODE(REPL_LFSR)) u_lfsr (
        .clk(clk), .rst(rst), .access_set(access_set), .access(access), .update(update),
        .repl_set(repl_set), .valid(valid), .repl_commit(repl_commit), .repl_index(idx_lfsr));
    repl_policy #(.SET_ASSOC(4), .SET_NUM(64), .MODE(REPL_PLRU)) u_plru (
        .clk(clk), .rst(rst), .access_set(access_set), .access(access), .update(update),
        .repl_set(repl_set), .valid(valid), .repl_commit(repl_commit), .repl_index(idx_plru));

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        update = 1'b0;
        repl_commit = 1'b0;
        #2;
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        valid = 4'hF;
        repl_set = 6'd0;
        #1;
        n_vec++; if (idx_rr !== 2'd0) begin n_err++; $display("FAIL reset_rr: got %0d expected 0", idx_rr); end
        n_vec++; if (idx_plru !== 2'd0) begin n_err++; $display("FAIL reset_plru: got %0d expected 0", idx_plru); end
        n_vec++; if (idx_lfsr !== 2'd1) begin n_err++; $display("FAIL reset_lfsr: got %0d expected 1", idx_lfsr); end
    endtask

    task automatic test_lfsr();
        do_reset();
        model = 16'hACE1;
        n_vec++; if (idx_lfsr !== 2'd1) begin n_err++; $display("FAIL lfsr_seed: got %0d expected 1", idx_lfsr); end
        for (int k = 0; k < 32; k++) begin
            cycle();
            model = {model[14:0], model[15] ^ model[13] ^ model[12] ^ model[10]};
            n_vec++;
            if (idx_lfsr !== model[1:0]) begin
                n_err++;
                $display("FAIL lfsr_seq[%0d]: got %0d expected %0d", k, idx_lfsr, model[1:0]);
            end
        end
        rst = 1'b0;
        #1;
        n_vec++; if (idx_lfsr !== 2'd1) begin n_err++; $display("FAIL lfsr_midreset: got %0d expected 1", idx_lfsr); end
        model = 16'hACE1;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            model = {model[14:0], model[15] ^ model[13] ^ model[12] ^ model[10]};
            n_vec++;
            if (idx_lfsr !== model[1:0]) begin
                n_err++;
                $display("FAIL lfsr_reseq[%0d]: got %0d expected %0d", k, idx_lfsr, model[1:0]);
            end
        end
    endtask

    task automatic test_plru_fill();
        repl_set = 6'd3;
        valid = 4'hF;
        #1;
        n_vec++; if (idx_plru !== 2'd0) begin n_err++; $display("FAIL fill_init: got %0d expected 0", idx_plru); end
        for (int w = 0; w < 4; w++) begin
            access_set = 6'd3;
            access = 4'b0001 << w;
            update = 1'b1;
            cycle();
            update = 1'b0;
            #1;
            n_vec++;
            if (idx_plru !== fill_exp[w]) begin
                n_err++;
                $display("FAIL fill_way%0d: got %0d expected %0d", w, idx_plru, fill_exp[w]);
            end
        end
        repl_set = 6'd5;
        #1;
        n_vec++; if (idx_plru !== 2'd0) begin n_err++; $display("FAIL fill_set5: got %0d expected 0", idx_plru); end
    endtask

    task automatic test_plru_path();
        repl_set = 6'd0;
        access_set = 6'd0;
        access = 4'b0001;
        update = 1'b1;
        #1;
        n_vec++; if (idx_plru !== 2'd0) begin n_err++; $display("FAIL path_nobypass: got %0d expected 0", idx_plru); end
        cycle();
        update = 1'b0;
        #1;
        n_vec++; if (idx_plru !== 2'd2) begin n_err++; $display("FAIL path_way0: got %0d expected 2", idx_plru); end
        access = 4'b0100;
        update = 1'b1;
        cycle();
        update = 1'b0;
        #1;
        n_vec++; if (idx_plru !== 2'd1) begin n_err++; $display("FAIL path_way2: got %0d expected 1", idx_plru); end
    endtask

    task automatic test_rr();
        repl_set = 6'd7;
        #1;
        n_vec++; if (idx_rr !== 2'd0) begin n_err++; $display("FAIL rr_init: got %0d expected 0", idx_rr); end
        access_set = 6'd7;
        access = 4'b0001;
        update = 1'b1;
        cycle();
        update = 1'b0;
        #1;
        n_vec++; if (idx_rr !== 2'd0) begin n_err++; $display("FAIL rr_ignore_update: got %0d expected 0", idx_rr); end
        for (int k = 0; k < 4; k++) begin
            repl_commit = 1'b1;
            cycle();
            repl_commit = 1'b0;
            #1;
            n_vec++;
            if (idx_rr !== rr_exp[k]) begin
                n_err++;
                $display("FAIL rr_commit%0d: got %0d expected %0d", k, idx_rr, rr_exp[k]);
            end
        end
        repl_set = 6'd6;
        #1;
        n_vec++; if (idx_rr !== 2'd0) begin n_err++; $display("FAIL rr_set6: got %0d expected 0", idx_rr); end
    endtask

    task automatic test_valid();
        repl_set = 6'd7;
        repl_commit = 1'b1;
        cycle();
        repl_commit = 1'b0;
        valid = 4'b1011;
        #1;
        n_vec++; if (idx_rr !== 2'd2) begin n_err++; $display("FAIL valid_rr: got %0d expected 2", idx_rr); end
        n_vec++; if (idx_lfsr !== 2'd2) begin n_err++; $display("FAIL valid_lfsr: got %0d expected 2", idx_lfsr); end
        n_vec++; if (idx_plru !== 2'd2) begin n_err++; $display("FAIL valid_plru: got %0d expected 2", idx_plru); end
        cycle();
        cycle();
        n_vec++; if (idx_rr !== 2'd2) begin n_err++; $display("FAIL valid_hold: got %0d expected 2", idx_rr); end
        valid = 4'hF;
        #1;
        n_vec++; if (idx_rr !== 2'd1) begin n_err++; $display("FAIL valid_nochange: got %0d expected 1", idx_rr); end
        valid = 4'b0000;
        #1;
        n_vec++; if (idx_rr !== 2'd0) begin n_err++; $display("FAIL none_rr: got %0d expected 0", idx_rr); end
        n_vec++; if (idx_lfsr !== 2'd0) begin n_err++; $display("FAIL none_lfsr: got %0d expected 0", idx_lfsr); end
        n_vec++; if (idx_plru !== 2'd0) begin n_err++; $display("FAIL none_plru: got %0d expected 0", idx_plru); end
        valid = 4'b0111;
        #1;
        n_vec++; if (idx_plru !== 2'd3) begin n_err++; $display("FAIL valid_top: got %0d expected 3", idx_plru); end
        valid = 4'hF;
    endtask

    task automatic test_same_cycle();
        repl_set = 6'd2;
        access_set = 6'd2;
        access = 4'b0010;
        update = 1'b1;
        repl_commit = 1'b1;
        cycle();
        update = 1'b0;
        repl_commit = 1'b0;
        #1;
        n_vec++; if (idx_plru !== 2'd2) begin n_err++; $display("FAIL same_plru: got %0d expected 2", idx_plru); end
        n_vec++; if (idx_rr !== 2'd1) begin n_err++; $display("FAIL same_rr: got %0d expected 1", idx_rr); end
        access_set = 6'd10;
        access = 4'b0001;
        update = 1'b1;
        repl_set = 6'd11;
        repl_commit = 1'b1;
        cycle();
        update = 1'b0;
        repl_commit = 1'b0;
        repl_set = 6'd10;
        #1;
        n_vec++; if (idx_plru !== 2'd2) begin n_err++; $display("FAIL diff_plru: got %0d expected 2", idx_plru); end
        n_vec++; if (idx_rr !== 2'd0) begin n_err++; $display("FAIL diff_rr10: got %0d expected 0", idx_rr); end
        repl_set = 6'd11;
        #1;
        n_vec++; if (idx_rr !== 2'd1) begin n_err++; $display("FAIL diff_rr11: got %0d expected 1", idx_rr); end
        access_set = 6'd12;
        access = 4'b0000;
        update = 1'b1;
        cycle();
        update = 1'b0;
        repl_set = 6'd12;
        #1;
        n_vec++; if (idx_plru !== 2'd0) begin n_err++; $display("FAIL zero_access: got %0d expected 0", idx_plru); end
        access_set = 6'd13;
        access = 4'b0110;
        update = 1'b1;
        cycle();
        update = 1'b0;
        repl_set = 6'd13;
        #1;
        n_vec++; if (idx_plru !== 2'd2) begin n_err++; $display("FAIL multi_access: got %0d expected 2", idx_plru); end
    endtask

    task automatic test_reset_async();
        repl_set = 6'd11;
        cycle();
        rst = 1'b0;
        repl_commit = 1'b1;
        #1;
        n_vec++; if (idx_rr !== 2'd0) begin n_err++; $display("FAIL async_rr: got %0d expected 0", idx_rr); end
        access_set = 6'd2;
        access = 4'b0001;
        update = 1'b1;
        cycle();
        n_vec++; if (idx_rr !== 2'd0) begin n_err++; $display("FAIL held_rr: got %0d expected 0", idx_rr); end
        repl_set = 6'd2;
        #1;
        n_vec++; if (idx_plru !== 2'd0) begin n_err++; $display("FAIL held_plru: got %0d expected 0", idx_plru); end
        update = 1'b0;
        repl_commit = 1'b0;
        rst = 1'b1;
        cycle();
        n_vec++; if (idx_plru !== 2'd0) begin n_err++; $display("FAIL release_plru: got %0d expected 0", idx_plru); end
    endtask

    initial begin
        test_reset();
        test_lfsr();
        test_plru_fill();
        test_plru_path();
        test_rr();
        test_valid();
        test_same_cycle();
        test_reset_async();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
